// File: rtl/rv32i_fetch_unit.sv
// RV32I instruction fetch stage: owns the fetch PC, captures words from a combinational
// instruction memory, and buffers {pc, instr} pairs in an in-order queue for decode.
module rv32i_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    output logic [31:0]                    imem_addr,
    input  logic [31:0]                    imem_instr,
    input  logic                           fetch_en,
    input  logic                           redirect_valid,
    input  logic [31:0]                    redirect_pc,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [31:0]                    out_instr,
    output logic [31:0]                    out_pc,
    output logic                           redirect_misaligned,
    output logic [$clog2(QUEUE_DEPTH):0]   queue_count
);

    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_q_pc    [QUEUE_DEPTH];
    logic [31:0]   r_q_instr [QUEUE_DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          r_misaligned;

    logic          w_pop;
    logic          w_push;
    logic          w_not_full;

    // Decode handshake: the head transfers on a cycle where out_valid and out_ready are both
    // high at the rising edge; a redirect in that same cycle cancels the transfer.
    assign w_not_full = (r_count < CW'(QUEUE_DEPTH));
    assign w_pop      = out_valid & out_ready & ~redirect_valid;
    assign w_push     = fetch_en & ~redirect_valid & (w_not_full | w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc   <= RESET_PC;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_misaligned <= 1'b0;
        end else if (redirect_valid) begin
            r_fetch_pc   <= {redirect_pc[31:2], 2'b00};
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_misaligned <= |redirect_pc[1:0];
        end else begin
            r_misaligned <= 1'b0;
            if (w_push) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
                r_wr_ptr   <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_q_pc[r_wr_ptr]    <= r_fetch_pc;
            r_q_instr[r_wr_ptr] <= imem_instr;
        end
    end

    assign imem_addr           = r_fetch_pc;
    assign out_valid           = (r_count != '0);
    assign out_pc              = r_q_pc[r_rd_ptr];
    assign out_instr           = r_q_instr[r_rd_ptr];
    assign redirect_misaligned = r_misaligned;
    assign queue_count         = r_count;

endmodule

// File: doc/rv32i_fetch_unit.md
# rv32i_fetch_unit

Instruction fetch stage for the RV32I core. It sits directly upstream of the combinational instruction memory: it owns the fetch PC, drives the memory byte address, and captures the returned word. Captured {pc, instr} pairs are buffered in a small in-order queue and handed to decode over a valid/ready handshake. Control-flow redirects from execute flush the queue and restart fetch at the new target.

## Interface
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset; bits [1:0] must be 0
- QUEUE_DEPTH, 2, instruction queue entries; power of two, ≥ 2
- clk  in  1  rising-edge clock, only clock in the block
- rst  in  1  synchronous, active-high reset
- imem_addr  out  32  byte address to instruction memory; equals fetch_pc register
- imem_instr  in  32  instruction word returned combinationally for imem_addr, same cycle
- fetch_en  in  1  when 0, no new fetches are pushed; drain and redirect still operate
- redirect_valid  in  1  one-cycle request to restart fetch
- redirect_pc  in  32  redirect target byte address
- out_valid  out  1  queue head holds a valid instruction
- out_ready  in  1  decode accepts head this cycle
- out_instr  out  32  instruction at queue head
- out_pc  out  32  byte PC of out_instr
- redirect_misaligned  out  1  one-cycle pulse: accepted redirect had redirect_pc[1:0] != 0
- queue_count  out  $clog2(QUEUE_DEPTH)+1  current occupancy

## Operation
- State: fetch_pc (32b), queue of QUEUE_DEPTH entries {pc, instr}, read/write pointers, count.
- pop = out_valid & out_ready & ~redirect_valid.
- push = fetch_en & ~redirect_valid & (count < QUEUE_DEPTH | pop).
- On push: write {fetch_pc, imem_instr} at wr_ptr; fetch_pc <= fetch_pc + 4 (mod 2^32; 0xFFFF_FFFC wraps to 0x0000_0000).
- On pop: rd_ptr advances; head removed.
- Push and pop in the same cycle: count unchanged; allowed when full (slot freed by pop is reused).
- Pointers wrap modulo QUEUE_DEPTH.
- Redirect (highest priority):
  - Queue flushed (count, pointers → 0).
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - Head is not popped, even if out_ready=1.
  - No push that cycle.
  - redirect_misaligned <= |redirect_pc[1:0] for one cycle.
- fetch_en=0: fetch_pc holds; queue drains normally.
- out_instr/out_pc drive the head entry directly from storage. Contents are don't-care when out_valid=0, but must not change while out_valid=1 and out_ready=0.
- Queue stores instructions opaquely; no decode is performed.

## Timing
- Reset (rst=1 at edge):
  - fetch_pc=RESET_PC, queue empty.
  - out_valid=0, queue_count=0, redirect_misaligned=0.
  - imem_addr=RESET_PC.
  - Reset overrides redirect, push and pop in the same cycle; mid-operation reset discards all queued entries.
- Fetch-to-decode latency: 1 cycle. A word captured at edge N is at the head with out_valid=1 after edge N. First out_valid=1 is the cycle after rst deasserts (fetch_en=1).
- Steady state with out_ready=1: one instruction per cycle, out_pc increasing by 4.
- Redirect latency: redirect_valid at edge N → out_valid=0 in cycle N+1 → target instruction valid in cycle N+2.
- Backpressure: with out_ready=0, queue fills in QUEUE_DEPTH cycles, after which fetch_pc stalls.
- imem_addr is a register output; no combinational path from any input to any output.

## Test plan
Memory below preloaded with the standard program: 0x00→00000013, 0x04→00a00093, 0x08→01400113, 0x40→008007ef, 0x44→12345737.
- Reset release, out_ready=1 → out_valid first high 1 cycle after rst low; (out_pc, out_instr) = (0x00, 00000013), (0x04, 00a00093), (0x08, 01400113) on consecutive cycles.
- out_ready=0 for 4 cycles after reset:
  - queue_count reaches 2; imem_addr stalls at 0x08.
  - Head holds (0x00, 00000013).
  - On out_ready=1, sequence resumes without loss or duplication.
- redirect_valid with redirect_pc=0x40 while the queue is full:
  - Next cycle out_valid=0 and queue_count=0.
  - Following cycle (0x40, 008007ef), then (0x44, 12345737).
  - redirect_misaligned stays 0.
- redirect_pc=0x46 → redirect_misaligned pulses 1 for exactly one cycle; fetch resumes at 0x44 with 12345737.
- Simultaneous redirect_valid and out_ready=1 with a valid head → head not counted as consumed; queue flushed; redirect target delivered next.
- rst asserted mid-stream at queue_count=2 → next cycle out_valid=0, queue_count=0, imem_addr=RESET_PC; stream restarts at 00000013.
